fsm_ctx_sched: RTL and testbench

Time-shared controller for the five-state A–E pattern engine. It serves `NCH` serial bit channels with one next-state engine. A per-channel context register file saves and restores each channel's state, and a round-robin arbiter picks one channel's bit per cycle. It sits between the per-channel bit sources and downstream hit consumers, replacing `NCH` separate copies of the A–E machine.

---
 rtl/fsm_ctx_sched_if.sv | 27 ++
 rtl/fsm_ctx_sched.sv | 111 +++++++++++
 tb/tb_fsm_ctx_sched.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/fsm_ctx_sched_if.sv
// Handshake and result bundle for the time-shared A-E pattern engine.
// Channel-side request/clear flags plus the registered result and hit counter.
interface fsm_ctx_sched_if #(
  parameter int unsigned NCH = 4,
  parameter int unsigned CW  = 2,
  parameter int unsigned HCW = 16
);
  logic [NCH-1:0] req_valid;
  logic [NCH-1:0] req_x;
  logic [NCH-1:0] req_ready;
  logic [NCH-1:0] ch_clr;
  logic           out_valid;
  logic [CW-1:0]  out_ch;
  logic [2:0]     out_state;
  logic           out_y;
  logic [HCW-1:0] hit_cnt;

  modport master (
    output req_valid, req_x, ch_clr,
    input  req_ready, out_valid, out_ch, out_state, out_y, hit_cnt
  );

  modport slave (
    input  req_valid, req_x, ch_clr,
    output req_ready, out_valid, out_ch, out_state, out_y, hit_cnt
  );
endinterface

// File: rtl/fsm_ctx_sched.sv
// One A-E next-state engine shared by NCH channels: per-channel context file,
// round-robin grant, one registered result per cycle and a saturating hit counter.
module fsm_ctx_sched #(
  parameter int unsigned NCH = 4,
  parameter int unsigned CW  = 2,
  parameter int unsigned HCW = 16
) (
  input logic            clk,
  input logic            reset,
  fsm_ctx_sched_if.slave bus
);

  typedef enum logic [2:0] {
    StA = 3'd0,
    StB = 3'd1,
    StC = 3'd2,
    StD = 3'd3,
    StE = 3'd4
  } state_e;

  logic [2:0]     ctx_q [NCH];
  logic [CW-1:0]  rr_q;
  logic [NCH-1:0] elig;
  logic [NCH-1:0] grant;
  logic           gnt_valid;
  logic [CW-1:0]  gnt_idx;
  logic [2:0]     cur_code;
  logic           cur_x;
  state_e         new_state;

  logic           out_valid_q;
  logic [CW-1:0]  out_ch_q;
  logic [2:0]     out_state_q;
  logic           out_y_q;
  logic [HCW-1:0] hit_q;

  assign elig = bus.req_valid & ~bus.ch_clr;

  // First eligible channel at or after rr, wrapping modulo NCH.
  always_comb begin
    int unsigned idx;
    grant     = '0;
    gnt_valid = 1'b0;
    gnt_idx   = '0;
    idx       = 0;
    for (int unsigned i = 0; i < NCH; i++) begin
      idx = (32'(rr_q) + i) % NCH;
      if (!gnt_valid && elig[idx]) begin
        gnt_valid  = 1'b1;
        gnt_idx    = CW'(idx);
        grant[idx] = 1'b1;
      end
    end
  end

  assign bus.req_ready = reset ? '0 : grant;

  // Next-state engine; codes 5..7 behave as A.
  always_comb begin
    cur_code  = ctx_q[gnt_idx];
    cur_x     = bus.req_x[gnt_idx];
    new_state = StA;
    case (cur_code)
      StA:     new_state = cur_x ? StC : StB;
      StB:     new_state = cur_x ? StD : StC;
      StC:     new_state = cur_x ? StC : StE;
      StD:     new_state = cur_x ? StE : StD;
      StE:     new_state = cur_x ? StD : StB;
      default: new_state = cur_x ? StC : StB;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < NCH; i++) begin
        ctx_q[i] <= StA;
      end
      rr_q        <= '0;
      out_valid_q <= 1'b0;
      out_ch_q    <= '0;
      out_state_q <= '0;
      out_y_q     <= 1'b0;
      hit_q       <= '0;
    end else begin
      // Cleared channels are never granted, so these never hit the updated entry.
      for (int unsigned i = 0; i < NCH; i++) begin
        if (bus.ch_clr[i]) begin
          ctx_q[i] <= StA;
        end
      end
      out_valid_q <= gnt_valid;
      if (gnt_valid) begin
        ctx_q[gnt_idx] <= new_state;
        rr_q           <= (gnt_idx == CW'(NCH - 1)) ? '0 : gnt_idx + CW'(1);
        out_ch_q       <= gnt_idx;
        out_state_q    <= new_state;
        out_y_q        <= (new_state == StE);
        if ((new_state == StE) && (hit_q != '1)) begin
          hit_q <= hit_q + HCW'(1);
        end
      end
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_ch    = out_ch_q;
  assign bus.out_state = out_state_q;
  assign bus.out_y     = out_y_q;
  assign bus.hit_cnt   = hit_q;

endmodule

// File: tb/tb_fsm_ctx_sched.sv
// Directed bench for fsm_ctx_sched: a default instance plus an HCW=2 twin
// fed the same inputs to observe counter saturation.
module tb_fsm_ctx_sched;

  logic clk;
  logic reset;
  int   errors;
  int   n_checks;

  fsm_ctx_sched_if #(.NCH(4), .CW(2), .HCW(16)) bus ();
  fsm_ctx_sched_if #(.NCH(4), .CW(2), .HCW(2))  bus2 ();

  fsm_ctx_sched #(.NCH(4), .CW(2), .HCW(16)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  fsm_ctx_sched #(.NCH(4), .CW(2), .HCW(2)) dut_sat (
    .clk   (clk),
    .reset (reset),
    .bus   (bus2.slave)
  );

  assign bus2.req_valid = bus.req_valid;
  assign bus2.req_x     = bus.req_x;
  assign bus2.ch_clr    = bus.ch_clr;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Apply inputs and let the combinational grant settle.
  task automatic drive(input logic [3:0] v, input logic [3:0] x, input logic [3:0] c);
    bus.req_valid = v;
    bus.req_x     = x;
    bus.ch_clr    = c;
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    drive(4'b0000, 4'b0000, 4'b0000);
    tick();
    reset = 1'b0;
  endtask

  initial begin
    errors   = 0;
    n_checks = 0;
    reset    = 1'b1;

    // Reset with every channel requesting
    drive(4'b1111, 4'b1111, 4'b0000);
    check("rst_ready", int'(bus.req_ready), 0);
    tick();
    check("rst_valid", int'(bus.out_valid), 0);
    check("rst_ch", int'(bus.out_ch), 0);
    check("rst_state", int'(bus.out_state), 0);
    check("rst_y", int'(bus.out_y), 0);
    check("rst_hit", int'(bus.hit_cnt), 0);
    reset = 1'b0;

    // Single channel, x=0,0,0 -> B, C, E
    drive(4'b0001, 4'b0000, 4'b0000);
    check("t1_ready", int'(bus.req_ready), 1);
    tick();
    check("t1_v0", int'(bus.out_valid), 1);
    check("t1_ch0", int'(bus.out_ch), 0);
    check("t1_s0", int'(bus.out_state), 1);
    check("t1_y0", int'(bus.out_y), 0);
    drive(4'b0001, 4'b0000, 4'b0000);
    tick();
    check("t1_s1", int'(bus.out_state), 2);
    check("t1_y1", int'(bus.out_y), 0);
    drive(4'b0001, 4'b0000, 4'b0000);
    tick();
    check("t1_s2", int'(bus.out_state), 4);
    check("t1_y2", int'(bus.out_y), 1);
    check("t1_hit", int'(bus.hit_cnt), 1);
    drive(4'b0000, 4'b0000, 4'b0000);
    check("t1_idle_ready", int'(bus.req_ready), 0);
    tick();
    check("t1_idle_valid", int'(bus.out_valid), 0);
    check("t1_hold_state", int'(bus.out_state), 4);

    // Round-robin interleave, x=1 everywhere
    do_reset();
    for (int c = 0; c < 8; c++) begin
      drive(4'b1111, 4'b1111, 4'b0000);
      check("t2_ready", int'(bus.req_ready), 1 << (c % 4));
      tick();
      check("t2_valid", int'(bus.out_valid), 1);
      check("t2_ch", int'(bus.out_ch), c % 4);
      check("t2_state", int'(bus.out_state), 2);
    end
    check("t2_hit", int'(bus.hit_cnt), 0);

    // Context isolation: ch1 x=1,1 and ch2 x=1,0 interleaved
    do_reset();
    drive(4'b0110, 4'b0110, 4'b0000);
    check("t3_ready_a", int'(bus.req_ready), 2);
    tick();
    check("t3_ch_a", int'(bus.out_ch), 1);
    check("t3_s_a", int'(bus.out_state), 2);
    drive(4'b0110, 4'b0110, 4'b0000);
    check("t3_ready_b", int'(bus.req_ready), 4);
    tick();
    check("t3_ch_b", int'(bus.out_ch), 2);
    check("t3_s_b", int'(bus.out_state), 2);
    drive(4'b0110, 4'b0010, 4'b0000);
    check("t3_ready_c", int'(bus.req_ready), 2);
    tick();
    check("t3_ch_c", int'(bus.out_ch), 1);
    check("t3_s_c", int'(bus.out_state), 2);
    drive(4'b0110, 4'b0010, 4'b0000);
    check("t3_ready_d", int'(bus.req_ready), 4);
    tick();
    check("t3_ch_d", int'(bus.out_ch), 2);
    check("t3_s_d", int'(bus.out_state), 4);
    check("t3_y_d", int'(bus.out_y), 1);
    drive(4'b0010, 4'b0000, 4'b0000);
    tick();
    check("t3_ch1_ctx", int'(bus.out_state), 4);
    check("t3_hit", int'(bus.hit_cnt), 2);

    // Clear masking on channel 0
    drive(4'b0001, 4'b0001, 4'b0000);
    tick();
    check("t4_pre", int'(bus.out_state), 2);
    for (int c = 0; c < 2; c++) begin
      drive(4'b0001, 4'b0000, 4'b0001);
      check("t4_clr_ready", int'(bus.req_ready), 0);
      tick();
      check("t4_clr_valid", int'(bus.out_valid), 0);
    end
    drive(4'b0001, 4'b0000, 4'b0000);
    check("t4_post_ready", int'(bus.req_ready), 1);
    tick();
    check("t4_post_state", int'(bus.out_state), 1);

    // Reset mid-operation
    drive(4'b1111, 4'b1111, 4'b0000);
    check("t5_ready_pre", int'(bus.req_ready), 2);
    tick();
    check("t5_ch_pre", int'(bus.out_ch), 1);
    reset = 1'b1;
    drive(4'b1111, 4'b1111, 4'b0000);
    check("t5_rst_ready", int'(bus.req_ready), 0);
    tick();
    check("t5_rst_valid", int'(bus.out_valid), 0);
    check("t5_rst_ch", int'(bus.out_ch), 0);
    check("t5_rst_state", int'(bus.out_state), 0);
    check("t5_rst_hit", int'(bus.hit_cnt), 0);
    reset = 1'b0;
    drive(4'b1111, 4'b0000, 4'b0000);
    check("t5_first_ready", int'(bus.req_ready), 1);
    tick();
    check("t5_first_ch", int'(bus.out_ch), 0);
    check("t5_first_state", int'(bus.out_state), 1);

    // Saturation: 15 zeros on ch0 give 5 hits; HCW=2 twin stops at 3
    do_reset();
    for (int i = 0; i < 15; i++) begin
      drive(4'b0001, 4'b0000, 4'b0000);
      tick();
      if (i == 8) begin
        check("t6_sat_at3", int'(bus2.hit_cnt), 3);
      end
    end
    check("t6_hit_wide", int'(bus.hit_cnt), 5);
    check("t6_hit_sat", int'(bus2.hit_cnt), 3);

    $display("Result: errors=%0d of %0d checks", errors, n_checks);
    $finish;
  end

endmodule
